cur_blk_fetch_sched: RTL and testbench
======================================

// Module: cur_blk_fetch_sched
// PURPOSE
//  Sequences one ME current-block fetch: reads ROWS words of the current block from cur memory.
//  Streams the words as cur0 into the 16-stage cur delay line.
//  Owns the ping-pong ref-bank lock flags only_read0/only_read1 feeding that delay line.
//  Sits between the top-level ME control (start/done) and the cur memory + delay/SAD datapath.
// PARAMETERS
//  ROWS      16  words fetched per block (one 16-bit word per row)
//  ADDR_W    8   cur memory address width
//  DELAY_LAT 16  downstream cur delay-line depth; sets drain time before done
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       asynchronous active-low reset
//  start        in   1       request one block fetch; sampled only in IDLE
//  blk_base     in   ADDR_W  block base address; latched when start is accepted
//  pause        in   1       hold fetch issue (level)
//  ref_ready0   in   1       ref bank 0 loaded and usable (level)
//  ref_ready1   in   1       ref bank 1 loaded and usable (level)
//  cur_rd_en    out  1       cur memory read strobe
//  cur_rd_addr  out  ADDR_W  cur memory read address
//  cur_rd_data  in   16      read data; valid 1 cycle after cur_rd_en
//  cur0         out  16      word to delay line (registered)
//  cur0_valid   out  1       cur0 holds a new word this cycle
//  only_read0   out  1       1 = ref bank 0 locked for SAD read, 0 = writable
//  only_read1   out  1       1 = ref bank 1 locked for SAD read, 0 = writable
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle pulse, block fully through delay line
// BEHAVIOUR
//  Reset (async, rst=0) state and outputs:
//   - state=IDLE, bank_sel=0, idx=0, drain_cnt=0
//   - all outputs 0; cur0=0
//  Reset mid-operation aborts the block; no done is produced.
//  FSM states: IDLE, WAIT_REF, FETCH, DRAIN.
//   IDLE: start=1 latches blk_base.
//    - If ref_ready[bank_sel]=1: -> FETCH.
//    - Otherwise: -> WAIT_REF.
//   WAIT_REF: -> FETCH on the first cycle with ref_ready[bank_sel]=1.
//   Entry to FETCH sets only_read[bank_sel]=1 (registered, visible the first FETCH cycle) and idx=0.
//  FETCH:
//   - cur_rd_en = (state==FETCH) & ~pause (combinational).
//   - cur_rd_addr = base_reg + idx, modulo 2^ADDR_W (wraps).
//   - idx increments only on cycles with cur_rd_en=1.
//   - pause=1 holds idx and issues no read; in-flight data still completes.
//   - The cycle issuing idx=ROWS-1 -> DRAIN; drain_cnt loaded with DELAY_LAT+1.
//  Data path:
//   - cur0 <= cur_rd_data and cur0_valid <= 1 in the cycle after a read was issued; else cur0_valid <= 0.
//   - cur0 holds its value when not valid.
//   - Latency from cur_rd_en to cur0_valid is 2 cycles.
//  DRAIN:
//   - drain_cnt decrements each cycle.
//   - done=1 when drain_cnt==1.
//   - So done occurs DELAY_LAT+2 cycles after the last cur_rd_en, i.e. exactly when the last word exits the delay line.
//   - Next cycle: -> IDLE, only_read[bank_sel] <= 0, bank_sel toggles.
//  Banks:
//   - Blocks alternate bank 0,1,0,...
//   - At most one only_read flag is 1 at any time.
//   - The unlocked bank is writable by the ref loader.
//  start is ignored while busy, including the done cycle; earliest re-accept is the cycle after done.
//  ref_ready falling during FETCH/DRAIN is ignored; the lock holds until the block ends.
//  pause during WAIT_REF or DRAIN has no effect.
// TESTING
//  1) Reset, ref_ready0=1, start@t0 with blk_base=0x10, no pause:
//     - cur_rd_en t0+1..t0+16, addr 0x10..0x1F.
//     - cur0_valid t0+3..t0+18.
//     - only_read0=1 t0+1..t0+34.
//     - done@t0+34; IDLE@t0+35.
//  2) pause=1 for 3 cycles mid-FETCH:
//     - addresses stay contiguous with no repeats.
//     - done shifted by exactly 3 cycles vs scenario 1.
//  3) Two back-to-back blocks, both ref_ready high:
//     - second block locks only_read1.
//     - only_read0 and only_read1 never high together.
//     - start in the done cycle is ignored.
//  4) ref_ready1=0 at start of second block:
//     - sits in WAIT_REF with cur_rd_en=0.
//     - proceeds one cycle after ref_ready1 rises.
//  5) blk_base=0xF8: addresses wrap 0xF8..0xFF,0x00..0x07.
//  6) rst low during FETCH:
//     - all outputs 0 immediately.
//     - the next start uses bank 0 and fetches a full ROWS words.

Source files
------------

// File: rtl/cur_blk_fetch_sched.sv
// Current-block fetch sequencer for motion estimation. It reads ROWS words of one block from cur
// memory into the cur delay line, and holds the ping-pong ref-bank lock until the block has drained.
module cur_blk_fetch_sched #(
   parameter int ROWS      = 16,
   parameter int ADDR_W    = 8,
   parameter int DELAY_LAT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] blk_base,
   input  logic              pause,
   input  logic              ref_ready0,
   input  logic              ref_ready1,
   output logic              cur_rd_en,
   output logic [ADDR_W-1:0] cur_rd_addr,
   input  logic [15:0]       cur_rd_data,
   output logic [15:0]       cur0,
   output logic              cur0_valid,
   output logic              only_read0,
   output logic              only_read1,
   output logic              busy,
   output logic              done
);
   localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CNT_W = $clog2(DELAY_LAT + 2);

   typedef enum logic [1:0] {IDLE, WAIT_REF, FETCH, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [CNT_W-1:0]  drain_q, drain_d;
   logic              bank_q, bank_d;
   logic [1:0]        lock_q, lock_d;
   logic              done_q, done_d;
   // [0]: read issued last cycle (data on cur_rd_data), [1]: cur0 holds a new word
   logic [1:0]        vld_pipe_q, vld_pipe_d;
   logic [15:0]       cur0_q, cur0_d;
   logic              ref_ok;

   assign ref_ok      = bank_q ? ref_ready1 : ref_ready0;
   assign cur_rd_en   = (state_q == FETCH) && !pause;
   assign cur_rd_addr = base_q + ADDR_W'(idx_q);
   assign cur0        = cur0_q;
   assign cur0_valid  = vld_pipe_q[1];
   assign only_read0  = lock_q[0];
   assign only_read1  = lock_q[1];
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      bank_d  = bank_q;
      lock_d  = lock_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               base_d = blk_base;
               if (ref_ok) begin
                  state_d = FETCH;
                  idx_d   = '0;
                  lock_d  = bank_q ? 2'b10 : 2'b01;
               end else begin
                  state_d = WAIT_REF;
               end
            end
         end
         WAIT_REF: begin
            if (ref_ok) begin
               state_d = FETCH;
               idx_d   = '0;
               lock_d  = bank_q ? 2'b10 : 2'b01;
            end
         end
         FETCH: begin
            if (cur_rd_en) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_W'(ROWS - 1)) begin
                  state_d = DRAIN;
                  drain_d = CNT_W'(DELAY_LAT + 1);
               end
            end
         end
         DRAIN: begin
            // done is registered, so the state stays in DRAIN for one extra cycle (count 0) while done is high
            if (drain_q != '0) drain_d = drain_q - 1'b1;
            if (drain_q == CNT_W'(1)) done_d = 1'b1;
            if (drain_q == '0) begin
               state_d = IDLE;
               lock_d  = 2'b00;
               bank_d  = ~bank_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vld_pipe_d = {vld_pipe_q[0], cur_rd_en};
      cur0_d     = vld_pipe_q[0] ? cur_rd_data : cur0_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         idx_q      <= '0;
         drain_q    <= '0;
         bank_q     <= 1'b0;
         lock_q     <= 2'b00;
         done_q     <= 1'b0;
         vld_pipe_q <= 2'b00;
         cur0_q     <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         drain_q    <= drain_d;
         bank_q     <= bank_d;
         lock_q     <= lock_d;
         done_q     <= done_d;
         vld_pipe_q <= vld_pipe_d;
         cur0_q     <= cur0_d;
      end
   end
endmodule

// File: tb/tb_cur_blk_fetch_sched.sv
// Directed bench for cur_blk_fetch_sched: a cycle-level expectation of each block is checked against the DUT,
// with a behavioural cur memory that has a one-cycle read latency.
module tb_cur_blk_fetch_sched;
   localparam int ROWS = 16;

   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, pause = 1'b0;
   logic        ref_ready0 = 1'b1, ref_ready1 = 1'b1;
   logic [7:0]  blk_base = 8'h00;
   logic [15:0] cur_rd_data = 16'h0000;
   logic        cur_rd_en, cur0_valid, only_read0, only_read1, busy, done;
   logic [7:0]  cur_rd_addr;
   logic [15:0] cur0;
   logic [15:0] cur0_exp = 16'h0000;
   int          total = 0, bad = 0;

   cur_blk_fetch_sched #(.ROWS(ROWS), .ADDR_W(8), .DELAY_LAT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .blk_base(blk_base), .pause(pause),
      .ref_ready0(ref_ready0), .ref_ready1(ref_ready1), .cur_rd_en(cur_rd_en),
      .cur_rd_addr(cur_rd_addr), .cur_rd_data(cur_rd_data), .cur0(cur0),
      .cur0_valid(cur0_valid), .only_read0(only_read0), .only_read1(only_read1),
      .busy(busy), .done(done));

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return {a ^ 8'h5A, a};
   endfunction

   always @(posedge clk) if (cur_rd_en) cur_rd_data <= mem_word(cur_rd_addr);

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_rd_en"}, cur_rd_en, 1'b0);
      chk({tag, "_addr"}, cur_rd_addr, 8'h00);
      chk({tag, "_cur0"}, cur0, 16'h0000);
      chk({tag, "_valid"}, cur0_valid, 1'b0);
      chk({tag, "_lock0"}, only_read0, 1'b0);
      chk({tag, "_lock1"}, only_read1, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   // Runs one block from the start cycle (k=0) to the first idle cycle after done.
   // The expected values follow the timing rules of the block, not its internal state.
   task automatic blk(input logic [7:0] base, input int bank, input int pstart, input int plen,
                      input int wcyc, input bit sdone);
      int n, F, donek;
      logic en_d1, en_d2, en_e, busy_e, lk, vld_e, finished;
      logic [7:0] a_d1, a_d2, a_e;
      n = 0; F = 1 + wcyc; donek = 0; finished = 1'b0;
      en_d1 = 1'b0; en_d2 = 1'b0; a_d1 = 8'h00; a_d2 = 8'h00;
      if (wcyc > 0) begin
         if (bank == 1) ref_ready1 = 1'b0; else ref_ready0 = 1'b0;
      end
      start = 1'b1; blk_base = base;
      for (int k = 1; k <= 200 && !finished; k++) begin
         @(negedge clk);
         start = 1'b0;
         pause = (k >= pstart) && (k < pstart + plen);
         if (wcyc > 0 && k == wcyc) begin
            if (bank == 1) ref_ready1 = 1'b1; else ref_ready0 = 1'b1;
         end
         if (sdone && donek != 0 && k == donek) start = 1'b1;
         #1;
         en_e   = (k >= F) && (n < ROWS) && !pause;
         a_e    = base + 8'(n);
         busy_e = (donek == 0) || (k <= donek);
         lk     = (k >= F) && busy_e;
         vld_e  = en_d2;
         if (vld_e) cur0_exp = mem_word(a_d2);
         chk("rd_en", cur_rd_en, en_e);
         if (en_e) chk("rd_addr", cur_rd_addr, a_e);
         chk("cur0_valid", cur0_valid, vld_e);
         chk("cur0", cur0, cur0_exp);
         chk("busy", busy, busy_e);
         chk("done", done, (donek != 0) && (k == donek));
         chk("only_read0", only_read0, (bank == 0) ? lk : 1'b0);
         chk("only_read1", only_read1, (bank == 1) ? lk : 1'b0);
         en_d2 = en_d1; a_d2 = a_d1;
         en_d1 = en_e;  a_d1 = a_e;
         if (en_e) begin
            n++;
            if (n == ROWS) donek = k + 18;
         end
         if (donek != 0 && k == donek + 1) finished = 1'b1;
      end
      start = 1'b0; pause = 1'b0;
      chk("blk_end", finished, 1'b1);
   endtask

   initial begin
      #12;
      chk_idle_outputs("reset");
      @(negedge clk); rst = 1'b1;
      #1 chk_idle_outputs("post_reset");

      // Plain fetch of a single block.
      blk(8'h10, 0, 0, 0, 0, 1'b0);
      // A 3-cycle pause in the middle of the fetch.
      blk(8'h20, 1, 6, 3, 0, 1'b0);
      // Two blocks back to back. A start asserted in the done cycle is ignored.
      blk(8'h30, 0, 0, 0, 0, 1'b1);
      blk(8'h50, 1, 0, 0, 0, 1'b0);
      // The ref bank is late: the block waits in WAIT_REF.
      blk(8'h40, 0, 0, 0, 0, 1'b0);
      blk(8'h60, 1, 0, 0, 4, 1'b0);
      // The address wraps past 0xFF.
      blk(8'hF8, 0, 0, 0, 0, 1'b0);

      // Reset asserted while fetching (this block would use bank 1).
      start = 1'b1; blk_base = 8'h70;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      #1 chk("pre_rst_rd_en", cur_rd_en, 1'b1);
      chk("pre_rst_lock1", only_read1, 1'b1);
      rst = 1'b0;
      #1;
      cur0_exp = 16'h0000;
      chk_idle_outputs("mid_rst");
      @(negedge clk); rst = 1'b1;
      #1 chk("rst_rel_busy", busy, 1'b0);
      blk(8'h80, 0, 0, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
